// File: rtl/serializer_pkg.sv
// Shared serdes definitions: FSM state encoding, default word width and
// bit-order encoding, common to the serializer and the 1:8 deserializer.
package serializer_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    // Bit-order encoding for the MSB_FIRST parameter.
    localparam bit ORDER_MSB_FIRST = 1'b1;
    localparam bit ORDER_LSB_FIRST = 1'b0;

    // IDLE: shift register empty; SHIFT: shift register transmitting.
    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } serdes_state_e;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter with a one-word holding register so that a
// continuously offered stream is sent with no idle gap between words.
module serializer
    import serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = ORDER_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] datain,
    input  logic             validIn,
    output logic             readyOut,
    output logic             dataout,
    output logic             validOut
);

    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serdes_state_e    state;
    logic [WIDTH-1:0] sr;       // bits still to be sent after the one on dataout
    logic [WIDTH-1:0] hr;
    logic             hr_full;
    logic [CW-1:0]    cnt;      // index of the bit currently on dataout
    logic             accept;

    // First bit of a word in the selected transmission order.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST == ORDER_MSB_FIRST) ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its first bit consumed, so the next bit sits at the head.
    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST == ORDER_MSB_FIRST) ? (w << 1) : (w >> 1);
    endfunction

    // Ready depends only on the registered holding-register flag.
    assign readyOut = ~hr_full;
    assign accept   = validIn & ~hr_full;

    // Two-state FSM with registered serial outputs, holding register and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            sr       <= '0;
            hr       <= '0;
            hr_full  <= 1'b0;
            cnt      <= '0;
            dataout  <= 1'b0;
            validOut <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (accept) begin
                        // Bypass HR: the word goes straight onto the line.
                        state    <= StShift;
                        dataout  <= head(datain);
                        sr       <= advance(datain);
                        cnt      <= '0;
                        validOut <= 1'b1;
                    end
                end
                StShift: begin
                    if (cnt == LAST) begin
                        if (hr_full) begin
                            dataout  <= head(hr);
                            sr       <= advance(hr);
                            cnt      <= '0;
                            hr       <= '0;
                            hr_full  <= 1'b0;
                            validOut <= 1'b1;
                        end else if (accept) begin
                            dataout  <= head(datain);
                            sr       <= advance(datain);
                            cnt      <= '0;
                            validOut <= 1'b1;
                        end else begin
                            state    <= StIdle;
                            sr       <= '0;
                            cnt      <= '0;
                            dataout  <= 1'b0;
                            validOut <= 1'b0;
                        end
                    end else begin
                        dataout <= head(sr);
                        sr      <= advance(sr);
                        cnt     <= cnt + CW'(1);
                        if (accept) begin
                            hr      <= datain;
                            hr_full <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/serializer.md
SERIALIZER -- requirements
Module: serializer

Interface
REQ-001 Parameter WIDTH, default 8, is the parallel word width in bits; legal values are 2 to 32.
REQ-002 Parameter MSB_FIRST, default 1, selects bit order: 1 sends datain[WIDTH-1] first, 0 sends datain[0] first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 datain  input  WIDTH  parallel word to transmit; sampled only on acceptance.
REQ-006 validIn  input  1  datain holds a word offered for transmission.
REQ-007 readyOut  output  1  block can accept a word this cycle.
REQ-008 dataout  output  1  serial bit, registered.
REQ-009 validOut  output  1  dataout carries a payload bit this cycle, registered.

Function
REQ-010 A word SHALL be accepted on a rising edge where validIn=1 and readyOut=1; no other edge changes the stored words.
REQ-011 The block SHALL hold one shift register (SR), one holding register (HR) with a full flag, and a bit counter of $clog2(WIDTH) bits.
REQ-012 readyOut SHALL equal the inverse of the HR full flag and SHALL be driven only from registered state, with no combinational path from validIn.
REQ-013 The FSM SHALL have exactly two states: IDLE (SR empty) and SHIFT (SR transmitting).
REQ-014 IDLE + accept: the word loads SR directly, bypassing HR; counter=0; next state SHIFT.
REQ-015 Latency: the first bit SHALL appear on dataout with validOut=1 in the cycle immediately after the accepting edge.
REQ-016 SHIFT: each edge SHALL advance one bit and increment the counter; validOut=1 for exactly WIDTH consecutive cycles per word.
REQ-017 SHIFT + accept while counter<WIDTH-1: the word is stored in HR and HR is marked full.
REQ-018 Last-bit edge (counter=WIDTH-1) with HR full: SR loads from HR, HR is cleared, counter=0, the state stays SHIFT, and no idle gap occurs.
REQ-019 Last-bit edge with HR empty and an accept on the same edge: the word loads SR directly and transmission continues gap-free.
REQ-020 Last-bit edge with HR empty and no accept: next state IDLE; validOut=0 and dataout=0 in the following cycle.
REQ-021 Sustained validIn=1 SHALL yield 100% serial throughput, with validOut never dropping between words.
REQ-022 The counter SHALL wrap from WIDTH-1 to 0 and SHALL never take a value at or above WIDTH.
REQ-023 dataout SHALL be 0 whenever validOut=0.
REQ-024 datain changes while the word is not being accepted SHALL have no effect.

Reset
REQ-025 While rst=1 on an edge: state=IDLE, SR=0, HR=0 and marked empty, counter=0; validOut=0, dataout=0, readyOut=1 after that edge.
REQ-026 rst SHALL take priority over acceptance: a word presented on a reset edge is discarded.
REQ-027 Reset mid-word SHALL abort transmission immediately, with no partial completion and the HR contents discarded.

Structure
REQ-028 The shared serdes package SHALL hold the FSM state enum, the default WIDTH constant and the bit-order encoding, common with the 1:8 deserializer.
REQ-029 No sub-module is required; the implementation is a single module with an SR, HR, counter and 2-state FSM.

Verification
REQ-030 Single word 0x9B, MSB_FIRST=1 -> dataout 1,0,0,1,1,0,1,1 over 8 cycles with validOut=1 starting one cycle after acceptance, then validOut=0 and dataout=0.
REQ-031 Back-to-back 0x9B then 0x36 with validIn held -> 16 contiguous validOut cycles; bits 1,0,0,1,1,0,1,1,0,0,1,1,0,1,1,0.
REQ-032 Three words 0xA5, 0x3C, 0xFF presented continuously -> readyOut falls after the 2nd acceptance and rises after the 1st word's last-bit edge; 24 contiguous valid bits.
REQ-033 rst asserted after 3 bits of 0xF0 with HR holding 0x0F -> next cycle validOut=0, dataout=0, readyOut=1; the next accept of 0x81 sends 1,0,0,0,0,0,0,1 only.
REQ-034 MSB_FIRST=0, word 0x9B -> dataout 1,1,0,1,1,0,0,1.
REQ-035 Random validIn gaps with a scoreboard paired to the deserializer -> every accepted word is recovered in order and validOut never exceeds WIDTH×(words accepted) cycles.
